// File: rtl/ex_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared definitions for the execute-stage multiply/divide unit: the four
// accepted ALU operation codes, the FSM state encoding, the legacy zero-word /
// register-bus constants and small opcode decode helpers.
// -----------------------------------------------------------------------------
package ex_muldiv_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    // Register-bus width and zero word shared with the rest of the EX stage.
    localparam int          REG_BUS_W = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_MUL = 2'd1,
        BUSY_DIV = 2'd2,
        DONE     = 2'd3
    } state_e;

    function automatic logic is_muldiv_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_mul_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// -----------------------------------------------------------------------------
// muldiv_sign_adj
// Conditional two's-complement negation. Used on entry to turn signed operands
// into magnitudes and on exit to restore the sign of the result.
//   i_value  W-bit input value
//   i_neg    1 = output the two's complement of i_value
//   o_value  W-bit result
// The most negative input negates to itself, which read as unsigned is exactly
// its magnitude 2^(W-1).
// -----------------------------------------------------------------------------
module muldiv_sign_adj #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_value,
    input  logic         i_neg,
    output logic [W-1:0] o_value
);

    assign o_value = i_neg ? (~i_value + W'(1)) : i_value;

endmodule

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv
// Iterative EX-stage multiply/divide unit (MULT/MULTU/DIV/DIVU) producing a
// HI/LO pair. One bit per cycle on unsigned magnitudes; sign fixed on exit.
//   clk, rst     clock, asynchronous active-high reset
//   start_i      request valid (held by ID/EX while stalled)
//   aluop_i      operation code, only the four mul/div codes are accepted
//   reg1_i       multiplicand / dividend
//   reg2_i       multiplier / divisor
//   annul_i      flush, aborts any operation and blocks acceptance
//   stallreq_o   combinational pipeline stall request
//   ready_o      result valid, one cycle (DONE state)
//   hi_o, lo_o   product high/low, or remainder/quotient
// -----------------------------------------------------------------------------
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        aluop_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              annul_i,
    output logic              stallreq_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    state_e              r_state, w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc_hi, r_acc_lo, r_opb;
    logic [DATA_W-1:0]   r_hi, r_lo;
    logic                r_neg_lo, r_neg_hi;

    logic                w_accept, w_signed_op, w_div_zero, w_busy, w_last;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b;
    logic [DATA_W:0]     w_mul_sum, w_div_shift;
    logic                w_div_ge;
    logic [DATA_W-1:0]   w_div_diff;
    logic [DATA_W-1:0]   w_step_hi, w_step_lo;
    logic [2*DATA_W-1:0] w_prod_adj, w_result;
    logic [DATA_W-1:0]   w_quo_adj, w_rem_adj;

    assign w_signed_op = is_signed_op(aluop_i);
    assign w_div_zero  = (reg2_i == '0);
    assign w_accept    = (r_state == IDLE) && start_i && is_muldiv_op(aluop_i) && !annul_i;
    assign w_busy      = (r_state == BUSY_MUL) || (r_state == BUSY_DIV);
    assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));

    // Operand entry: magnitudes of the incoming operands.
    muldiv_sign_adj #(.W(DATA_W)) u_mag_a (
        .i_value (reg1_i),
        .i_neg   (w_signed_op && reg1_i[DATA_W-1]),
        .o_value (w_mag_a)
    );
    muldiv_sign_adj #(.W(DATA_W)) u_mag_b (
        .i_value (reg2_i),
        .i_neg   (w_signed_op && reg2_i[DATA_W-1]),
        .o_value (w_mag_b)
    );

    // Shift-add step: LO holds the remaining multiplier bits, HI the partial
    // sum; the add carry shifts down into HI's MSB.
    assign w_mul_sum = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opb : '0)};

    // Restoring step: shift {rem, quo} left by one, subtract when it fits.
    // When it fits the true difference is below 2^DATA_W, so the low bits
    // of the subtraction are exact.
    assign w_div_shift = {r_acc_hi, r_acc_lo[DATA_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_opb;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_step_hi = w_div_ge ? w_div_diff : w_div_shift[DATA_W-1:0];
        w_step_lo = {r_acc_lo[DATA_W-2:0], w_div_ge};
        if (r_state == BUSY_MUL) begin
            w_step_hi = w_mul_sum[DATA_W:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
        end
    end

    // Result exit: the final step's value is sign-corrected on its way into
    // hi_o/lo_o, so no extra correction cycle is needed.
    muldiv_sign_adj #(.W(2*DATA_W)) u_adj_prod (
        .i_value ({w_step_hi, w_step_lo}),
        .i_neg   (r_neg_lo),
        .o_value (w_prod_adj)
    );
    muldiv_sign_adj #(.W(DATA_W)) u_adj_quo (
        .i_value (w_step_lo),
        .i_neg   (r_neg_lo),
        .o_value (w_quo_adj)
    );
    muldiv_sign_adj #(.W(DATA_W)) u_adj_rem (
        .i_value (w_step_hi),
        .i_neg   (r_neg_hi),
        .o_value (w_rem_adj)
    );

    assign w_result = (r_state == BUSY_MUL) ? w_prod_adj : {w_rem_adj, w_quo_adj};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; annul overrides everything except reset.
    always_comb begin
        w_next_state = r_state;
        if (annul_i) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (is_mul_op(aluop_i)) w_next_state = BUSY_MUL;
                        else if (w_div_zero)    w_next_state = DONE;
                        else                    w_next_state = BUSY_DIV;
                    end
                end
                BUSY_MUL, BUSY_DIV: if (w_last) w_next_state = DONE;
                DONE:               w_next_state = IDLE;
                default:            w_next_state = IDLE;
            endcase
        end
    end

    // Outputs. DONE drops the stall so the pipeline advances at its end.
    always_comb begin
        ready_o    = (r_state == DONE);
        stallreq_o = !annul_i && (w_accept || w_busy);
    end

    // Datapath.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are plain registers, so all of them are reset; a large
        // storage array would be left unreset instead.
        if (rst) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= w_mag_a;
            r_opb    <= w_mag_b;
            r_neg_lo <= w_signed_op && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
            r_neg_hi <= w_signed_op && reg1_i[DATA_W-1];
            // Divide by zero skips iteration: dividend as given, all-ones quotient.
            if (!is_mul_op(aluop_i) && w_div_zero) begin
                r_hi <= reg1_i;
                r_lo <= '1;
            end
        end else if (w_busy && !annul_i) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            if (w_last) begin
                r_hi <= w_result[2*DATA_W-1:DATA_W];
                r_lo <= w_result[DATA_W-1:0];
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv
// Self-checking bench for ex_muldiv (DATA_W=32). Expected results come from a
// plain-arithmetic reference (64-bit products, native / and %).
// -----------------------------------------------------------------------------
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  aluop_i = 8'h00;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic        annul_i = 1'b0;
    logic        stallreq_o, ready_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .aluop_i    (aluop_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .ready_o    (ready_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: results straight from signed/unsigned arithmetic.
    function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint          sa, sb, p, q, r;
        longint unsigned up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 33;
        hi  = '0;
        lo  = '0;
        if (op == EXE_MULT_OP) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0];
        end else if (op == EXE_MULTU_OP) begin
            up = {32'h0, a} * {32'h0, b};
            hi = up[63:32]; lo = up[31:0];
        end else if (b == 32'h0) begin
            hi = a; lo = 32'hFFFF_FFFF; lat = 1;
        end else if (op == EXE_DIV_OP) begin
            q = sa / sb; r = sa % sb;
            hi = r[31:0]; lo = q[31:0];
        end else begin
            hi = a % b; lo = a / b;
        end
    endfunction

    // Drive a request just after a falling edge: this is cycle A.
    task automatic launch(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b;
        #1;
        check("stall_at_accept", stallreq_o, 1'b1);
    endtask

    // Wait (bounded) for ready_o, then check latency, stall pattern, results
    // and that ready_o lasts one cycle with no re-acceptance.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [31:0] eh, input logic [31:0] el);
        int k = 0;
        bit seen = 1'b0;
        bit stall_ok = 1'b1;
        while (!seen && k < exp_lat + 8) begin
            @(negedge clk);
            k++;
            if (ready_o) seen = 1'b1;
            else if (stallreq_o !== 1'b1) stall_ok = 1'b0;
        end
        check({tag, "_latency"}, seen ? 64'(k) : 64'hDEAD, 64'(exp_lat));
        check({tag, "_stall_busy"}, stall_ok, 1'b1);
        check({tag, "_stall_done"}, stallreq_o, 1'b0);
        check({tag, "_hi"}, hi_o, eh);
        check({tag, "_lo"}, lo_o, el);
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_ready_1cyc"}, {ready_o, stallreq_o}, 2'b00);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int lat;
        model(op, a, b, eh, el, lat);
        @(negedge clk);
        launch(op, a, b);
        wait_result(tag, lat, eh, el);
    endtask

    initial begin : stim
        logic [7:0]  ops [4];
        logic [31:0] specials [5];
        logic [31:0] a, b, hold_hi, hold_lo;
        logic [7:0]  op;
        bit          quiet;

        ops      = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
        specials = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000};

        // Reset state.
        #2;
        check("reset_outputs", {ready_o, stallreq_o, hi_o, lo_o}, {2'b00, ZERO_WORD, ZERO_WORD});
        @(negedge clk);
        rst = 1'b0;

        // Directed operations with hand-computed results.
        @(negedge clk); launch(EXE_MULT_OP, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_result("mult_neg3x5", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        @(negedge clk); launch(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk); launch(EXE_DIV_OP, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_result("div_7_neg2", 33, 32'h0000_0001, 32'hFFFF_FFFD);
        @(negedge clk); launch(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_result("divu_max_2", 33, 32'h0000_0001, 32'h7FFF_FFFF);
        @(negedge clk); launch(EXE_DIV_OP, 32'h1234_5678, 32'h0000_0000);
        wait_result("div_by_zero", 1, 32'h1234_5678, 32'hFFFF_FFFF);
        @(negedge clk); launch(EXE_DIVU_OP, 32'h8000_0000, 32'h0000_0000);
        wait_result("divu_by_zero", 1, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk); launch(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_minint_neg1", 33, 32'h0000_0000, 32'h8000_0000);

        // Non-mul/div opcode is ignored.
        @(negedge clk);
        start_i = 1'b1; aluop_i = 8'h25; reg1_i = 32'h5; reg2_i = 32'h3;
        #1;
        check("other_op_no_stall", stallreq_o, 1'b0);
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ready_o || stallreq_o) quiet = 1'b0;
        end
        check("other_op_ignored", quiet, 1'b1);
        start_i = 1'b0;

        // Annul in IDLE blocks acceptance.
        @(negedge clk);
        start_i = 1'b1; aluop_i = EXE_MULT_OP; annul_i = 1'b1;
        #1;
        check("annul_idle_stall", stallreq_o, 1'b0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        quiet = 1'b1;
        repeat (36) begin
            @(negedge clk);
            if (ready_o || stallreq_o) quiet = 1'b0;
        end
        check("annul_idle_no_op", quiet, 1'b1);

        // Annul mid-division at A+10, then a new MULT accepted at A+11.
        hold_hi = hi_o; hold_lo = lo_o;
        @(negedge clk); launch(EXE_DIV_OP, 32'h0765_4321, 32'h0000_0013);
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ready_o) quiet = 1'b0;
        end
        annul_i = 1'b1;
        #1;
        check("annul_busy_stall", stallreq_o, 1'b0);
        @(negedge clk);
        annul_i = 1'b0;
        if (ready_o) quiet = 1'b0;
        check("annul_no_ready", quiet, 1'b1);
        check("annul_hold_hilo", {hi_o, lo_o}, {hold_hi, hold_lo});
        launch(EXE_MULT_OP, 32'h0001_0003, 32'hFFFF_FFF9);
        wait_result("mult_after_annul", 33, 32'hFFFF_FFFF, 32'hFFF8_FFEB);

        // Randomized operations against the reference model.
        for (int i = 0; i < 20; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 31);
            run_op($sformatf("rand%0d_op%0h", i, op), op, a, b);
        end

        // Asynchronous reset between edges at A+5 of a multiply.
        @(negedge clk); launch(EXE_MULTU_OP, 32'h0000_1234, 32'h0000_5678);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1; start_i = 1'b0;
        #1;
        check("async_rst_outputs", {ready_o, stallreq_o, hi_o, lo_o}, {2'b00, 64'h0});
        #3;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (ready_o || stallreq_o) quiet = 1'b0;
        end
        check("after_rst_no_ready", quiet, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
